// File: rtl/button_stepper.sv
// button_stepper: turns one raw push-button into clean step strobes.
// Path: two-flop synchroniser -> debounce counter -> press/hold/release FSM.
// Emits one btn_pulse per accepted press, optional auto-repeat while held,
// and one btn_rel per accepted release. All outputs are registered.
module button_stepper #(
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 8,
  parameter int CNT_W         = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_rel
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    REL_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic             REPEAT_EN = (REPEAT_DELAY > 0);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             s1;
  logic             s2;
  logic             level_next;
  logic             pulse_next;
  logic             rel_next;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= CNT_ZERO;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
      btn_rel   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      btn_level <= level_next;
      btn_pulse <= pulse_next;
      btn_rel   <= rel_next;
    end
  end

  // Next-state, counter and strobe decode; strobes default low every cycle.
  // With auto-repeat disabled, HELD parks the counter at zero so it can
  // never run up to its maximum value while the button stays down.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = btn_level;
    pulse_next = 1'b0;
    rel_next   = 1'b0;
    case (state)
      IDLE: begin
        level_next = 1'b0;
        cnt_next   = CNT_ZERO;
        if (s2) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_next = IDLE;
          cnt_next   = CNT_ZERO;
        end else if (cnt == DB_LAST) begin
          state_next = HELD;
          cnt_next   = CNT_ZERO;
          level_next = 1'b1;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!s2) begin
          state_next = REL_WAIT;
          cnt_next   = CNT_ONE;
        end else if (REPEAT_EN && (cnt == RD_LAST)) begin
          state_next = REPEAT;
          cnt_next   = CNT_ZERO;
          pulse_next = 1'b1;
        end else if (REPEAT_EN) begin
          cnt_next = cnt + CNT_ONE;
        end else begin
          cnt_next = CNT_ZERO;
        end
      end
      REPEAT: begin
        if (!s2) begin
          state_next = REL_WAIT;
          cnt_next   = CNT_ONE;
        end else if (cnt == RP_LAST) begin
          cnt_next   = CNT_ZERO;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      REL_WAIT: begin
        if (s2) begin
          state_next = HELD;
          cnt_next   = CNT_ZERO;
        end else if (cnt == DB_LAST) begin
          state_next = IDLE;
          cnt_next   = CNT_ZERO;
          level_next = 1'b0;
          rel_next   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = CNT_ZERO;
        level_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_stepper.sv
// Bench for button_stepper: two instances share clk/rst/btn.
// dut_a: DB=4, no auto-repeat.  dut_b: DB=4, repeat delay 8, period 3.
// Edge numbering restarts at 0 after each reset; "edge n" is the n-th
// rising edge with rst high, and outputs are sampled 1 time unit after it.
module tb_button_stepper;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic level_a, pulse_a, rel_a;
  logic level_b, pulse_b, rel_b;

  always #5 clk = ~clk;

  button_stepper #(.DB_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .btn(btn),
    .btn_level(level_a), .btn_pulse(pulse_a), .btn_rel(rel_a)
  );

  button_stepper #(.DB_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .btn(btn),
    .btn_level(level_b), .btn_pulse(pulse_b), .btn_rel(rel_b)
  );

  typedef struct {
    logic rst;
    logic btn;
    int   hold;
    logic exp_level_a;
    logic exp_level_b;
    int   exp_pa;
    int   exp_pb;
    int   exp_ra;
    int   exp_rb;
  } vec_t;

  vec_t vecs[13];

  int compared   = 0;
  int mismatched = 0;
  int edge_no    = 0;
  int seg_pa, seg_pb, seg_ra, seg_rb;
  logic prev_pa, prev_pb;
  int pa_q[$];
  int pb_q[$];
  int ra_q[$];
  int rb_q[$];
  int want_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkEdges(input string name, input int got[$], input int want[$]);
    checkOutput($sformatf("%s_count", name), got.size(), want.size());
    for (int i = 0; i < got.size() && i < want.size(); i++)
      checkOutput($sformatf("%s_edge%0d", name, i), got[i], want[i]);
  endtask

  // One rising edge: sample, run the per-edge invariants, log strobes.
  task automatic runEdge();
    logic rst_seen;
    rst_seen = rst;
    @(posedge clk);
    #1;
    if (rst_seen) edge_no++;
    if (!rst_seen)
      checkOutput("reset_clear", {level_a, pulse_a, rel_a, level_b, pulse_b, rel_b}, 0);
    checkOutput("pulse_rel_excl_a", pulse_a & rel_a, 0);
    checkOutput("pulse_rel_excl_b", pulse_b & rel_b, 0);
    if (prev_pa) checkOutput("back_to_back_a", pulse_a, 0);
    if (prev_pb) checkOutput("back_to_back_b", pulse_b, 0);
    if (pulse_a === 1'b1) begin pa_q.push_back(edge_no); seg_pa++; end
    if (pulse_b === 1'b1) begin pb_q.push_back(edge_no); seg_pb++; end
    if (rel_a === 1'b1) begin ra_q.push_back(edge_no); seg_ra++; end
    if (rel_b === 1'b1) begin rb_q.push_back(edge_no); seg_rb++; end
    prev_pa = pulse_a;
    prev_pb = pulse_b;
  endtask

  task automatic applyStimulus(input logic r, input logic b, input int n);
    rst = r;
    btn = b;
    seg_pa = 0; seg_pb = 0; seg_ra = 0; seg_rb = 0;
    repeat (n) runEdge();
  endtask

  task automatic startScenario();
    applyStimulus(1'b0, 1'b0, 2);
    rst = 1'b1;
    edge_no = 0;
    prev_pa = 1'b0;
    prev_pb = 1'b0;
    pa_q.delete(); pb_q.delete(); ra_q.delete(); rb_q.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0;
    btn = 1'b0;
    prev_pa = 1'b0;
    prev_pb = 1'b0;

    // Clean press and release, then a bounce, then reset with button held.
    vecs[0]  = '{1'b1, 1'b1, 5,  1'b0, 1'b0, 0, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1, 1, 0, 0};
    vecs[2]  = '{1'b1, 1'b1, 13, 1'b1, 1'b1, 0, 2, 0, 0};
    vecs[3]  = '{1'b1, 1'b0, 5,  1'b1, 1'b1, 0, 1, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 0, 0, 1, 1};
    vecs[5]  = '{1'b1, 1'b0, 5,  1'b0, 1'b0, 0, 0, 0, 0};
    vecs[6]  = '{1'b1, 1'b1, 1,  1'b0, 1'b0, 0, 0, 0, 0};
    vecs[7]  = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 0, 0, 0, 0};
    vecs[8]  = '{1'b1, 1'b1, 1,  1'b0, 1'b0, 0, 0, 0, 0};
    vecs[9]  = '{1'b1, 1'b0, 16, 1'b0, 1'b0, 0, 0, 0, 0};
    vecs[10] = '{1'b0, 1'b1, 2,  1'b0, 1'b0, 0, 0, 0, 0};
    vecs[11] = '{1'b1, 1'b1, 5,  1'b0, 1'b0, 0, 0, 0, 0};
    vecs[12] = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1, 1, 0, 0};

    startScenario();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].btn, vecs[i].hold);
      checkOutput($sformatf("vec%0d_level_a", i), level_a, vecs[i].exp_level_a);
      checkOutput($sformatf("vec%0d_level_b", i), level_b, vecs[i].exp_level_b);
      checkOutput($sformatf("vec%0d_pulses_a", i), seg_pa, vecs[i].exp_pa);
      checkOutput($sformatf("vec%0d_pulses_b", i), seg_pb, vecs[i].exp_pb);
      checkOutput($sformatf("vec%0d_rels_a", i), seg_ra, vecs[i].exp_ra);
      checkOutput($sformatf("vec%0d_rels_b", i), seg_rb, vecs[i].exp_rb);
    end

    // Auto-repeat: btn sampled high on edges 1..29, low from edge 30.
    startScenario();
    applyStimulus(1'b1, 1'b1, 29);
    applyStimulus(1'b1, 1'b0, 11);
    want_q = '{6, 14, 17, 20, 23, 26, 29};
    checkEdges("repeat_pulses_b", pb_q, want_q);
    checkOutput("repeat_steps_b", pb_q.size(), 7);
    want_q = '{6};
    checkEdges("repeat_pulses_a", pa_q, want_q);
    want_q = '{35};
    checkEdges("repeat_rel_a", ra_q, want_q);
    checkEdges("repeat_rel_b", rb_q, want_q);

    // Release glitch: btn low on edges 8 and 9 only, seen by the FSM at 10-11.
    startScenario();
    applyStimulus(1'b1, 1'b1, 7);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 3);
    checkOutput("glitch_level_a", level_a, 1);
    checkOutput("glitch_level_b", level_b, 1);
    checkOutput("glitch_no_rel_a", ra_q.size(), 0);
    checkOutput("glitch_no_rel_b", rb_q.size(), 0);
    applyStimulus(1'b1, 1'b1, 12);
    applyStimulus(1'b1, 1'b0, 10);
    want_q = '{6, 20, 23, 26};
    checkEdges("glitch_pulses_b", pb_q, want_q);
    want_q = '{6};
    checkEdges("glitch_pulses_a", pa_q, want_q);
    want_q = '{30};
    checkEdges("glitch_rel_a", ra_q, want_q);
    checkEdges("glitch_rel_b", rb_q, want_q);

    // Mid-press reset while dut_b is in REPEAT; button stays held.
    startScenario();
    applyStimulus(1'b1, 1'b1, 15);
    applyStimulus(1'b0, 1'b1, 1);
    edge_no = 16;
    applyStimulus(1'b1, 1'b1, 5);
    checkOutput("midrst_level_b_before", level_b, 0);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("midrst_level_b_after", level_b, 1);
    checkOutput("midrst_level_a_after", level_a, 1);
    applyStimulus(1'b1, 1'b1, 3);
    want_q = '{6, 14, 22};
    checkEdges("midrst_pulses_b", pb_q, want_q);
    want_q = '{6, 22};
    checkEdges("midrst_pulses_a", pa_q, want_q);
    checkOutput("midrst_no_rel_a", ra_q.size(), 0);
    checkOutput("midrst_no_rel_b", rb_q.size(), 0);

    startScenario();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
